rptr_empty: RTL and testbench

Read-domain pointer and empty-flag generator for the asynchronous FIFO. Consumes the write pointer synchronized into the read clock domain by the 2-FF write-to-read synchronizer and maintains the binary read address, the Gray-coded read pointer, and the registered empty flag. It also provides a sticky underflow error and, optionally, a fill level with an almost-empty flag. Its `rptr` output feeds the read-to-write synchronizer and its `raddr` drives the FIFO memory read port.

---
 rtl/rptr_empty_pkg.sv | 13 +
 rtl/rptr_empty_gray2bin.sv | 16 +
 rtl/rptr_empty.sv | 80 ++++++++
 tb/tb_rptr_empty.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rptr_empty_pkg.sv
// Shared FIFO definitions: default address width, almost-empty threshold
// and reset values used by the read-side pointer/empty block.
package rptr_empty_pkg;

    localparam int unsigned ADDR_SIZE_DEF = 6;
    localparam int unsigned PTR_W_DEF     = ADDR_SIZE_DEF + 1;
    localparam int unsigned AE_THRESH_DEF = 2;

    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_UNDERFLOW    = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// Gray-to-binary converter of configurable width (XOR prefix from the MSB).
module gray2bin #(
    parameter int unsigned WIDTH = 7
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty flag and sticky underflow for the async FIFO.
// Optional fill level / almost-empty outputs are built under RPTR_EMPTY_LEVEL_EN.
module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input  logic                 r_clk,
    input  logic                 r_rstn,
    input  logic                 r_inc,
    input  logic [ADDR_SIZE:0]   syn_wptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 r_empty,
    output logic                 r_underflow,
    output logic [ADDR_SIZE:0]   r_level,
    output logic                 r_almost_empty
);

    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] rbin_next;
    logic [ADDR_SIZE:0] rgray_next;
    logic               rd_ok;

    always_comb begin
        rd_ok      = r_inc & ~r_empty;
        rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, rd_ok};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    // Full-width Gray compare: the MSB separates laps so empty never aliases.
    always_ff @(posedge r_clk) begin
        if (!r_rstn) begin
            rbin        <= '0;
            rptr        <= '0;
            r_empty     <= RST_EMPTY;
            r_underflow <= RST_UNDERFLOW;
        end else begin
            rbin        <= rbin_next;
            rptr        <= rgray_next;
            r_empty     <= (rgray_next == syn_wptr);
            r_underflow <= r_underflow | (r_inc & r_empty);
        end
    end

    assign raddr = rbin[ADDR_SIZE-1:0];

`ifdef RPTR_EMPTY_LEVEL_EN
    localparam logic [ADDR_SIZE:0] AE_LIM = AE_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] level_next;

    gray2bin #(
        .WIDTH(ADDR_SIZE + 1)
    ) u_wbin (
        .gray(syn_wptr),
        .bin (wbin)
    );

    always_comb begin
        level_next = wbin - rbin_next;
    end

    always_ff @(posedge r_clk) begin
        if (!r_rstn) begin
            r_level        <= '0;
            r_almost_empty <= RST_ALMOST_EMPTY;
        end else begin
            r_level        <= level_next;
            r_almost_empty <= (level_next <= AE_LIM);
        end
    end
`else
    assign r_level        = '0;
    assign r_almost_empty = r_empty;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty: stimulus pushes expected post-edge state,
// a negedge monitor pops and compares. Honours RPTR_EMPTY_LEVEL_EN.
module tb_rptr_empty;

    localparam int unsigned AS = 6;
    localparam int unsigned PW = AS + 1;

    logic          r_clk = 1'b0;
    logic          r_rstn;
    logic          r_inc;
    logic [PW-1:0] syn_wptr;
    logic [AS-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          r_empty;
    logic          r_underflow;
    logic [PW-1:0] r_level;
    logic          r_almost_empty;

    rptr_empty #(
        .ADDR_SIZE(AS),
        .AE_THRESH(2)
    ) dut (
        .r_clk         (r_clk),
        .r_rstn        (r_rstn),
        .r_inc         (r_inc),
        .syn_wptr      (syn_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .r_empty       (r_empty),
        .r_underflow   (r_underflow),
        .r_level       (r_level),
        .r_almost_empty(r_almost_empty)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        string         tag;
        logic [PW-1:0] rptr;
        logic [AS-1:0] raddr;
        logic          empty;
        logic          uf;
        logic [PW-1:0] level;
        logic          ae;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: plain integer read/write counts.
    int m_rd  = 0;
    int m_wr  = 0;
    bit m_emp = 1'b1;
    bit m_uf  = 1'b0;

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % 128);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    // One clock of stimulus; wr is the write count whose Gray code is presented.
    task automatic cycle(input string tag, input bit rstn, input bit inc, input int wr);
        exp_t e;
        int   lvl;
        r_rstn   = rstn;
        r_inc    = inc;
        m_wr     = wr;
        syn_wptr = to_gray(wr);
        if (!rstn) begin
            m_rd  = 0;
            m_emp = 1'b1;
            m_uf  = 1'b0;
            lvl   = 0;
        end else begin
            if (inc && m_emp) m_uf = 1'b1;
            if (inc && !m_emp) m_rd = (m_rd + 1) % 128;
            m_emp = ((m_wr % 128) == m_rd);
            lvl   = ((m_wr - m_rd) % 128 + 128) % 128;
        end
        e.tag   = tag;
        e.rptr  = to_gray(m_rd);
        e.raddr = AS'(m_rd % 64);
        e.empty = m_emp;
        e.uf    = m_uf;
`ifdef RPTR_EMPTY_LEVEL_EN
        e.level = PW'(lvl);
        e.ae    = (lvl <= 2);
`else
        e.level = '0;
        e.ae    = m_emp;
`endif
        @(posedge r_clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge r_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rptr",  e.tag, int'(rptr),           int'(e.rptr));
                chk("raddr", e.tag, int'(raddr),          int'(e.raddr));
                chk("empty", e.tag, int'(r_empty),        int'(e.empty));
                chk("uflow", e.tag, int'(r_underflow),    int'(e.uf));
                chk("level", e.tag, int'(r_level),        int'(e.level));
                chk("aempty", e.tag, int'(r_almost_empty), int'(e.ae));
            end
        end
    end

    initial begin : stim
        int w;
        r_rstn   = 1'b0;
        r_inc    = 1'b1;
        syn_wptr = '0;
        #1;

        // Reset held two cycles while a read is requested.
        cycle("reset", 1'b0, 1'b1, 0);
        cycle("reset", 1'b0, 1'b1, 0);

        // Single entry written then read.
        cycle("single_wr", 1'b1, 1'b0, 1);
        cycle("single_rd", 1'b1, 1'b1, 1);
        cycle("single_idle", 1'b1, 1'b0, 1);

        // Underflow: read while empty, flag sticks through idle.
        cycle("uflow_req", 1'b1, 1'b1, 1);
        for (int i = 0; i < 10; i++) cycle("uflow_hold", 1'b1, 1'b0, 1);
        cycle("uflow_rst", 1'b0, 1'b0, 0);

        // Wrap: write count advances one per cycle up to 130 with continuous reads.
        for (int k = 0; k < 136; k++) begin
            w = (k + 1 > 130) ? 130 : k + 1;
            cycle("wrap", 1'b1, 1'b1, w);
        end
        cycle("wrap_end", 1'b1, 1'b0, 130);

        // Level / almost-empty around the threshold.
        cycle("lvl_rst", 1'b0, 1'b0, 0);
        cycle("lvl_fill", 1'b1, 1'b0, 10);
        for (int k = 0; k < 7; k++) cycle("lvl_to3", 1'b1, 1'b1, 10);
        cycle("lvl_to2", 1'b1, 1'b1, 10);
        cycle("lvl_to1", 1'b1, 1'b1, 10);
        cycle("lvl_idle", 1'b1, 1'b0, 10);

        // Let the monitor drain, bounded.
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(posedge r_clk);
        @(negedge r_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
